// File: rtl/var_slice_sweeper.sv
// Holds each accepted word on A and sweeps offset B from 0 to OFF_LAST in steps of OFF_STEP.
// Latency: first (A,B) beat one cycle after accept; one beat per cycle while OUT_READY is high.
// Backpressure: A/B hold while OUT_READY=0; the next word is accepted in the same cycle as the last beat.
module var_slice_sweeper #(
  parameter int WORD_W   = 32,
  parameter int OFF_W    = 4,
  parameter int OFF_STEP = 1,
  parameter int OFF_LAST = 15,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [WORD_W-1:0] A,
  output logic [OFF_W-1:0]  B,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic [CNT_W-1:0]  WORD_CNT
);

  typedef enum logic {IDLE, SWEEP} state_t;

  // One extra bit so the next offset is compared without wrapping.
  localparam logic [OFF_W:0] STEP_EXT = (OFF_W+1)'(OFF_STEP);
  localparam logic [OFF_W:0] LAST_EXT = (OFF_W+1)'(OFF_LAST);

  state_t         state;
  logic [OFF_W:0] b_next;
  logic           last_beat;

  // Next offset and last-beat detection; stepping past OFF_LAST marks the final beat.
  always_comb begin
    b_next    = {1'b0, B} + STEP_EXT;
    last_beat = OUT_VALID & (b_next > LAST_EXT);
  end

  assign OUT_LAST = last_beat;
  assign IN_READY = (state == IDLE) | (last_beat & OUT_READY);
  assign BUSY     = (state == SWEEP);

  // Sweep controller: load word, step offset on each taken beat, chain or retire at the end.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      A         <= '0;
      B         <= '0;
      OUT_VALID <= 1'b0;
      WORD_CNT  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            A         <= IN_DATA;
            B         <= '0;
            OUT_VALID <= 1'b1;
            state     <= SWEEP;
          end
        end
        SWEEP: begin
          if (OUT_READY) begin
            if (last_beat) begin
              WORD_CNT <= WORD_CNT + CNT_W'(1);
              if (IN_VALID) begin
                A <= IN_DATA;
                B <= '0;
              end else begin
                OUT_VALID <= 1'b0;
                state     <= IDLE;
              end
            end else begin
              B <= b_next[OFF_W-1:0];
            end
          end
        end
        default: begin
          state     <= IDLE;
          OUT_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule
